register_file_loader: RTL and testbench

REGISTER_FILE_LOADER -- requirements
Module: register_file_loader

---
 rtl/register_file_loader.sv | 154 +++++++++++++++
 tb/tb_register_file_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_loader.sv
// Register file loader: takes a burst of words from a valid/ready source and
// writes them to consecutive register-file entries. The write address wraps
// modulo 2^ADDR_WIDTH.
// Optional feature: define LOADER_CHECKSUM_EN to add a running Checksum output.
// Checksum is the modulo-2^DATA_WIDTH sum of all words written in the current burst.
module register_file_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] StartAddress,
  input  logic [ADDR_WIDTH:0]   Length,
  input  logic                  Abort,
  input  logic                  InValid,
  input  logic [DATA_WIDTH-1:0] InData,
  output logic                  InReady,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteValue,
  output logic                  Busy,
`ifdef LOADER_CHECKSUM_EN
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Checksum
`else
  output logic                  Done
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  accept;
  logic                  start_accept;

  // The source may only hand over words while a burst is loading.
  // A burst is considered in progress until its FINISH cycle has passed.
  assign InReady = (state == LOAD);
  assign Busy    = (state != IDLE);

  // Next-state logic and address/count bookkeeping.
  // Abort is checked before last-word completion so an aborted burst never reaches FINISH.
  always_comb begin
    state_next   = state;
    addr_next    = addr;
    count_next   = count;
    accept       = 1'b0;
    start_accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          start_accept = 1'b1;
          addr_next    = StartAddress;
          count_next   = Length;
          if (Length == '0) begin
            state_next = FINISH;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        accept = InValid;
        if (accept) begin
          addr_next  = addr + ADDR_ONE;
          count_next = count - COUNT_ONE;
        end
        if (Abort) begin
          state_next = IDLE;
        end else if (accept && (count == COUNT_ONE)) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, address and remaining-count registers.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
      addr  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
      count <= count_next;
    end
  end

  // Registered write port: every accepted word appears on the write port one cycle later.
  // The address and value hold their last value between writes.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      WriteValue   <= '0;
    end else begin
      WriteEnable <= accept;
      if (accept) begin
        WriteAddress <= addr;
        WriteValue   <= InData;
      end
    end
  end

  // Done is a one-cycle pulse that follows the FINISH cycle.
  // Because it trails FINISH by one cycle, it lands one cycle after the final write.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Done <= 1'b0;
    end else begin
      Done <= (state == FINISH);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of the burst's written words.
  // It is cleared when a new burst is accepted and holds its value once the burst ends.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Checksum <= '0;
    end else if (start_accept) begin
      Checksum <= '0;
    end else if (accept) begin
      Checksum <= Checksum + InData;
    end
  end
`else
  // The burst-start indication only feeds the checksum.
  // This keeps it visibly consumed when the checksum is left out.
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_register_file_loader.sv
// Self-checking bench for register_file_loader: directed scenarios followed by
// randomized traffic, all compared against a burst-level reference model.
module tb_register_file_loader;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          Clock = 1'b0;
  logic          ResetN = 1'b0;
  logic          Start = 1'b0;
  logic [AW-1:0] StartAddress = '0;
  logic [AW:0]   Length = '0;
  logic          Abort = 1'b0;
  logic          InValid = 1'b0;
  logic [DW-1:0] InData = '0;
  logic          InReady;
  logic          WriteEnable;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] WriteValue;
  logic          Busy;
  logic          Done;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] Checksum;
`endif

  register_file_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .Start(Start),
    .StartAddress(StartAddress),
    .Length(Length),
    .Abort(Abort),
    .InValid(InValid),
    .InData(InData),
    .InReady(InReady),
    .WriteEnable(WriteEnable),
    .WriteAddress(WriteAddress),
    .WriteValue(WriteValue),
    .Busy(Busy),
`ifdef LOADER_CHECKSUM_EN
    .Done(Done),
    .Checksum(Checksum)
`else
    .Done(Done)
`endif
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Burst-level model: whether a burst is loading or finishing, the words still owed,
  // the next entry to write, and the outputs expected after the coming edge.
  bit            m_loading;
  bit            m_finishing;
  int            m_left;
  int            m_next;
  bit            m_we;
  bit            m_done;
  int            m_wa;
  logic [DW-1:0] m_wv;
  logic [DW-1:0] m_chk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("write_enable", WriteEnable, m_we);
    check("write_address", WriteAddress, m_wa);
    check("write_value", WriteValue, m_wv);
    check("done", Done, m_done);
    check("busy", Busy, m_loading || m_finishing);
    check("in_ready", InReady, m_loading);
`ifdef LOADER_CHECKSUM_EN
    check("checksum", Checksum, m_chk);
`endif
  endtask

  task automatic model_reset();
    m_loading   = 1'b0;
    m_finishing = 1'b0;
    m_left      = 0;
    m_next      = 0;
    m_we        = 1'b0;
    m_done      = 1'b0;
    m_wa        = 0;
    m_wv        = '0;
    m_chk       = '0;
  endtask

  // One clock cycle: drive inputs, advance the model, then check the outputs just after the edge.
  task automatic applyStimulus(input bit st, input int sa, input int len, input bit ab,
                               input bit v, input logic [DW-1:0] d);
    bit acc;
    bit n_loading;
    bit n_finishing;
    Start        = st;
    StartAddress = sa[AW-1:0];
    Length       = len[AW:0];
    Abort        = ab;
    InValid      = v;
    InData       = d;
    acc          = m_loading && v;
    n_loading    = m_loading;
    n_finishing  = 1'b0;
    m_done       = m_finishing;
    m_we         = acc;
    if (acc) begin
      m_wa   = m_next;
      m_wv   = d;
      m_next = (m_next + 1) % DEPTH;
      m_left = m_left - 1;
      m_chk  = m_chk + d;
    end
    if (!m_loading && !m_finishing) begin
      if (st) begin
        m_chk = '0;
        if (len == 0) begin
          n_finishing = 1'b1;
        end else begin
          n_loading = 1'b1;
          m_left    = len;
          m_next    = sa;
        end
      end
    end else if (m_loading) begin
      if (ab) begin
        n_loading = 1'b0;
      end else if (acc && m_left == 0) begin
        n_loading   = 1'b0;
        n_finishing = 1'b1;
      end
    end
    m_loading   = n_loading;
    m_finishing = n_finishing;
    @(posedge Clock);
    #1;
    checkOutput();
  endtask

  // Drop reset mid-cycle, check that the outputs clear at once, then release it away from an edge.
  task automatic reset_now();
    ResetN = 1'b0;
    #1;
    model_reset();
    checkOutput();
    @(posedge Clock);
    #1;
    ResetN = 1'b1;
  endtask

  initial begin
    model_reset();
    reset_now();

    // Basic three-word burst at address 5.
    applyStimulus(1, 5, 3, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 1, 16'hA001);
    applyStimulus(0, 0, 0, 0, 1, 16'hA002);
    applyStimulus(0, 0, 0, 0, 1, 16'hA003);
    applyStimulus(0, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);
`ifdef LOADER_CHECKSUM_EN
    check("checksum_e006", Checksum, 16'hE006);
`endif

    // Address wrap across the top of the register file.
    applyStimulus(1, 1022, 4, 0, 0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 16'h1000 + 16'(i));
    applyStimulus(0, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);

    // Stalls on alternating valid.
    applyStimulus(1, 100, 4, 0, 0, '0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, (i % 2) == 0, 16'h2000 + 16'(i));
    applyStimulus(0, 0, 0, 0, 0, '0);

    // Zero-length burst.
    applyStimulus(1, 33, 0, 0, 1, 16'h5555);
    applyStimulus(0, 0, 0, 0, 1, 16'h5556);
    applyStimulus(0, 0, 0, 0, 1, 16'h5557);

    // Abort after two of five words, with an ignored Start during the burst.
    applyStimulus(1, 200, 5, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 1, 16'h3001);
    applyStimulus(1, 900, 2, 0, 1, 16'h3002);
    applyStimulus(0, 0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 0, 1, 16'h3003);
    applyStimulus(0, 0, 0, 0, 0, '0);

    // Abort coinciding with the last word: the word is written but no Done follows.
    applyStimulus(1, 300, 2, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 1, 16'h4001);
    applyStimulus(0, 0, 0, 1, 1, 16'h4002);
    applyStimulus(0, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);

    // Abort while idle or finishing has no effect.
    applyStimulus(0, 0, 0, 1, 1, '0);
    applyStimulus(1, 50, 1, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 1, 16'h6001);
    applyStimulus(0, 0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);

    // Reset after three of eight words; no writes follow the release.
    applyStimulus(1, 400, 8, 0, 0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 16'h7000 + 16'(i));
    reset_now();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 16'h7100 + 16'(i));

    // Maximum-length burst covering every entry.
    applyStimulus(1, 7, DEPTH, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 1, 16'($urandom));
    applyStimulus(0, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int len;
      len = (($urandom % 5) == 0) ? int'($urandom % (DEPTH + 1)) % 40 : int'($urandom % 10);
      applyStimulus(($urandom % 6) == 0, int'($urandom % DEPTH), len,
                    ($urandom % 25) == 0, ($urandom % 3) != 0, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
